// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states, FIFO entry layout and word size.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int INST_BYTES = 4;
  localparam int ENTRY_W    = 33;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO holding {last, data} program words; read data is registered
// and only changes on a pop or an explicit clear.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     rd_clr,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic [ENTRY_W-1:0] rd_data_r;
  logic               full_s;
  logic               empty_s;
  logic               do_push_s;
  logic               do_pop_s;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_s   = (count_r == (AW+1)'(0));
  assign do_pop_s  = pop && !empty_s && !flush;
  // A push into a full FIFO is only legal when the same cycle frees a slot.
  assign do_push_s = push && !flush && (!full_s || do_pop_s);

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      count_r   <= (AW+1)'(0);
      rd_data_r <= {ENTRY_W{1'b0}};
    end else begin
      if (flush) begin
        wr_ptr_r <= AW'(0);
        rd_ptr_r <= AW'(0);
        count_r  <= (AW+1)'(0);
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
      end
      if (rd_clr) begin
        rd_data_r <= {ENTRY_W{1'b0}};
      end else if (do_pop_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign rd_data = rd_data_r;
  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_r;

endmodule

// File: rtl/program_loader.sv
// Streams a program into cpp_processor via inst/instAddr/load, then lets it run for a
// programmed number of cycles and pulses done.
module program_loader
  import loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      inst,
  output logic [31:0]      instAddr,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      word_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_r;
  logic [31:0]      base_r;
  logic [31:0]      inst_addr_r;
  logic [31:0]      word_count_r;
  logic [CNT_W-1:0] run_cycles_r;
  logic [CNT_W-1:0] cyc_r;
  logic             load_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             in_ready_r;
  logic             last_acc_r;
  logic             popped_r;

  entry_t           wr_entry_s;
  entry_t           rd_entry_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [CW-1:0]    count_next_s;
  logic             start_ok_s;
  logic             push_s;
  logic             pop_s;
  logic             ovf_s;
  logic             flush_s;
  logic             last_seen_s;
  logic             run_end_s;
  logic             full_next_s;
  logic             last_acc_next_s;

  assign wr_entry_s      = {in_last, in_data};
  assign start_ok_s      = start && (state_r == IDLE);
  assign push_s          = in_valid && in_ready_r && !fifo_full_s;
  assign ovf_s           = (state_r == LOAD) && !fifo_empty_s && (word_count_r == 32'(MAX_WORDS));
  assign pop_s           = (state_r == LOAD) && !fifo_empty_s && !ovf_s;
  assign flush_s         = start_ok_s || ovf_s;
  // The last word becomes visible one cycle after its pop, while load is still high.
  assign last_seen_s     = (state_r == LOAD) && popped_r && rd_entry_s.last;
  assign run_end_s       = (run_cycles_r == CNT_W'(0)) || (cyc_r == run_cycles_r - CNT_W'(1));
  assign count_next_s    = flush_s ? CW'(0) : (fifo_count_s + CW'(push_s) - CW'(pop_s));
  assign full_next_s     = (count_next_s == CW'(FIFO_DEPTH));
  assign last_acc_next_s = last_acc_r || (push_s && in_last);

  loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_s),
    .rd_clr  (start_ok_s),
    .push    (push_s),
    .wr_data (wr_entry_s),
    .pop     (pop_s),
    .rd_data (rd_entry_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Control FSM with address generation, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      base_r       <= 32'h0;
      inst_addr_r  <= 32'h0;
      word_count_r <= 32'h0;
      run_cycles_r <= {CNT_W{1'b0}};
      cyc_r        <= {CNT_W{1'b0}};
      load_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      in_ready_r   <= 1'b0;
      last_acc_r   <= 1'b0;
      popped_r     <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      popped_r   <= pop_s;
      last_acc_r <= last_acc_next_s;
      if (pop_s) begin
        inst_addr_r  <= base_r + word_count_r * 32'(INST_BYTES);
        word_count_r <= word_count_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= LOAD;
            base_r       <= base_addr;
            run_cycles_r <= run_cycles;
            inst_addr_r  <= base_addr;
            word_count_r <= 32'h0;
            err_r        <= 1'b0;
            last_acc_r   <= 1'b0;
            load_r       <= 1'b1;
            busy_r       <= 1'b1;
            in_ready_r   <= 1'b1;
          end else begin
            load_r     <= 1'b0;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        LOAD: begin
          if (ovf_s) begin
            state_r    <= DONE;
            err_r      <= 1'b1;
            done_r     <= 1'b1;
            load_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end else if (last_seen_s) begin
            state_r    <= RUN;
            cyc_r      <= {CNT_W{1'b0}};
            load_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end else begin
            load_r     <= 1'b1;
            in_ready_r <= !full_next_s && !last_acc_next_s;
          end
        end
        RUN: begin
          if (run_end_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            cyc_r <= cyc_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          load_r     <= 1'b0;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign inst       = rd_entry_s.data;
  assign instAddr   = inst_addr_r;
  assign load       = load_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized programs
// checked against a write-list model built from the loading rules.
module tb_program_loader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] run_cycles;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] inst;
  logic [31:0] instAddr;
  logic        load;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] word_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] words [0:7];

  program_loader #(
    .FIFO_DEPTH (2),
    .MAX_WORDS  (MAXW),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .inst       (inst),
    .instAddr   (instAddr),
    .load       (load),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {in_ready, load, busy, done, err}, 64'h0);
    chk({tag, "_inst"}, inst, 64'h0);
    chk({tag, "_addr"}, instAddr, 64'h0);
    chk({tag, "_wc"}, word_count, 64'h0);
  endtask

  // Feeds words[0..n-1] and checks the writes seen on the processor port against the rules:
  // word i goes to base+4*i, at most MAXW words, overflow sets err, run lasts max(rc,1) cycles.
  task automatic run_prog(input logic [31:0] base, input logic [15:0] rc, input int n,
                          input bit with_last, input bit stall, input bit poke, input string tag);
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] cur;
    int nw, idx, run_cnt, done_cnt, cyc, exp_run, lim;
    bit exp_err, seen_done, poked;
    logic [31:0] d_inst, d_addr, d_wc;
    logic d_err;
    nw      = (n > MAXW) ? MAXW : n;
    exp_err = (n > MAXW);
    exp_run = exp_err ? 0 : ((rc == 16'd0) ? 1 : int'(rc));
    if (words[0] != 32'h0) exp_q.push_back({base, 32'h0});
    for (int i = 0; i < nw; i++) exp_q.push_back({base + 32'(4 * i), words[i]});
    idx = 0; run_cnt = 0; done_cnt = 0; cyc = 0;
    seen_done = 1'b0; poked = 1'b0;
    d_inst = 32'h0; d_addr = 32'h0; d_wc = 32'h0; d_err = 1'b0;
    start = 1'b1; base_addr = base; run_cycles = rc; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 500) begin
      if (load) begin
        cur = {instAddr, inst};
        if (got_q.size() == 0 || got_q[$] != cur) got_q.push_back(cur);
      end
      if (busy && !load && !done) run_cnt++;
      if (seen_done) break;
      if (done) begin
        done_cnt++; seen_done = 1'b1;
        d_inst = inst; d_addr = instAddr; d_wc = word_count; d_err = err;
      end
      if (idx < n) begin
        in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = words[idx];
        in_last  = with_last && (idx == n - 1);
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0; in_data = $urandom; in_last = 1'b0;
      end
      if (poke && !poked && busy && !load && !done) begin
        start = 1'b1; base_addr = $urandom; run_cycles = 16'd0; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    chk({tag, "_done_seen"}, seen_done, 1'b1);
    chk({tag, "_done_cnt"}, done_cnt, 64'(1));
    chk({tag, "_after_done"}, {done, busy, load}, 64'h0);
    chk({tag, "_err"}, d_err, exp_err);
    chk({tag, "_err_sticky"}, err, exp_err);
    chk({tag, "_wc"}, d_wc, 64'(nw));
    chk({tag, "_run_cycles"}, run_cnt, 64'(exp_run));
    chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_hold_addr"}, d_addr, exp_q[$][63:32]);
    if (!exp_err) chk({tag, "_hold_inst"}, d_inst, exp_q[$][31:0]);
  endtask

  task automatic abort_test(input int k, input bit expect_load, input string tag);
    bit sent;
    int dn;
    sent = 1'b0; dn = 0;
    start = 1'b1; base_addr = $urandom; run_cycles = 16'd100;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < k; c++) begin
      if (!sent) begin
        in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
        if (in_ready) sent = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk({tag, "_pre"}, {busy, load}, {62'h0, 1'b1, expect_load});
    rst = 1'b1;
    @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk({tag, "_nodone"}, dn, 64'h0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  initial begin
    int n;
    bit wl;
    rst = 1'b1; start = 1'b0; base_addr = 32'h0; run_cycles = 16'd0;
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Words offered while idle must not be accepted.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);

    words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
    run_prog(32'h0000_0100, 16'd5, 3, 1'b1, 1'b0, 1'b0, "t1t2");

    fill_random(6);
    run_prog(32'h0000_2000, 16'd3, 4, 1'b1, 1'b1, 1'b0, "t3_stall");

    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    run_prog(32'hFFFF_FFFC, 16'd2, 2, 1'b1, 1'b0, 1'b0, "t4_wrap");

    fill_random(6);
    run_prog(32'h0000_4000, 16'd4, 6, 1'b0, 1'b0, 1'b0, "t5_ovf");
    fill_random(2);
    run_prog(32'h0000_5000, 16'd1, 2, 1'b1, 1'b0, 1'b0, "t5_clear");

    abort_test(1, 1'b1, "t6_rst_load");
    abort_test(8, 1'b0, "t6_rst_run");
    words[0] = 32'h0;
    run_prog(32'h0000_6000, 16'd0, 1, 1'b1, 1'b0, 1'b1, "t6_rc0_poke");

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 6);
      wl = (n > MAXW) ? 1'($urandom_range(0, 1)) : 1'b1;
      fill_random(n);
      run_prog(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom,
               16'($urandom_range(0, 8)), n, wl, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
